// File: rtl/uart_tx_sched.sv
// Scheduler in front of the UART TX FIFO: paced 0xAA sync bytes while the link is down, then
// round-robin framed packets (HDR, ID, PH, PL[, CSUM]). Define UART_TX_SCHED_CHECKSUM_EN for the CSUM byte.
module uart_tx_sched #(
    parameter int          N_REQ    = 3,
    parameter int          SYNC_GAP = 1000,
    parameter logic [7:0]  HDR_BYTE = 8'h55
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 link_up,
    input  logic                 tx_full,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  payload,
    output logic [N_REQ-1:0]     gnt,
    output logic [7:0]           w_data,
    output logic                 wr_uart,
    output logic                 busy
);
    localparam int              CNT_W     = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(SYNC_GAP - 1);
    localparam logic [2:0]      LAST_REQ  = 3'(N_REQ - 1);
    localparam logic [7:0]      SYNC_BYTE = 8'hAA;

`ifdef UART_TX_SCHED_CHECKSUM_EN
    typedef enum logic [2:0] {SYNC_WAIT, SYNC_SEND, IDLE, HDR, ID, PH, PL, CSUM} state_t;
`else
    typedef enum logic [2:0] {SYNC_WAIT, SYNC_SEND, IDLE, HDR, ID, PH, PL} state_t;
`endif

    state_t             state_q, state_d, after_emit;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         idx_q, idx_d;
    logic [15:0]        pay_q, pay_d;
    logic [N_REQ-1:0]   gnt_d;
    logic [7:0]         data_d;
    logic               wr_d;
    logic               busy_d;
    logic               emit;
    logic [7:0]         byte_val;

    logic               found;
    logic [2:0]         sel;
    logic [15:0]        sel_payload;
    logic [N_REQ-1:0]   sel_onehot;

    // Round-robin pick: first request at or above the pointer, else first below it (wrap).
    always_comb begin
        found       = 1'b0;
        sel         = '0;
        sel_payload = '0;
        sel_onehot  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (3'(i) >= ptr_q)) begin
                found = 1'b1;
                sel   = 3'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (3'(i) < ptr_q)) begin
                found = 1'b1;
                sel   = 3'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (sel == 3'(i)) begin
                sel_payload   = payload[16*i +: 16];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        byte_val = SYNC_BYTE;
        case (state_q)
            HDR:     byte_val = HDR_BYTE;
            ID:      byte_val = {5'b0, idx_q};
            PH:      byte_val = pay_q[15:8];
            PL:      byte_val = pay_q[7:0];
`ifdef UART_TX_SCHED_CHECKSUM_EN
            CSUM:    byte_val = HDR_BYTE ^ {5'b0, idx_q} ^ pay_q[15:8] ^ pay_q[7:0];
`endif
            default: byte_val = SYNC_BYTE;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        after_emit = state_q;
        gap_d      = '0;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        pay_d      = pay_q;
        gnt_d      = '0;
        wr_d       = 1'b0;
        data_d     = w_data;
        emit       = 1'b0;
        case (state_q)
            SYNC_WAIT: begin
                if (link_up)
                    state_d = IDLE;
                else if (gap_q == GAP_LAST)
                    state_d = SYNC_SEND;
                else
                    gap_d = gap_q + 1'b1;
            end
            SYNC_SEND: begin
                emit       = 1'b1;
                after_emit = link_up ? IDLE : SYNC_WAIT;
            end
            IDLE: begin
                if (!link_up) begin
                    state_d = SYNC_WAIT;
                end else if (found) begin
                    gnt_d   = sel_onehot;
                    idx_d   = sel;
                    pay_d   = sel_payload;
                    ptr_d   = (sel == LAST_REQ) ? 3'd0 : sel + 3'd1;
                    state_d = HDR;
                end
            end
            HDR: begin emit = 1'b1; after_emit = ID; end
            ID:  begin emit = 1'b1; after_emit = PH; end
            PH:  begin emit = 1'b1; after_emit = PL; end
`ifdef UART_TX_SCHED_CHECKSUM_EN
            PL:   begin emit = 1'b1; after_emit = CSUM; end
            CSUM: begin emit = 1'b1; after_emit = IDLE; end
`else
            PL:  begin emit = 1'b1; after_emit = IDLE; end
`endif
            default: state_d = SYNC_WAIT;
        endcase
        // A full FIFO holds the state so the same byte is offered again next cycle.
        if (emit) begin
            if (tx_full) begin
                data_d = '0;
            end else begin
                wr_d    = 1'b1;
                data_d  = byte_val;
                state_d = after_emit;
            end
        end
        busy_d = (state_d != SYNC_WAIT) && (state_d != SYNC_SEND) && (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SYNC_WAIT;
            gap_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            pay_q   <= '0;
            gnt     <= '0;
            wr_uart <= 1'b0;
            w_data  <= SYNC_BYTE;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            pay_q   <= pay_d;
            gnt     <= gnt_d;
            wr_uart <= wr_d;
            w_data  <= data_d;
            busy    <= busy_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: expected packets and grants are queued when requests are issued and
// popped by an independent monitor; sync pacing is checked from the gap arithmetic.
`timescale 1ns/1ps
module tb_uart_tx_sched;
    localparam int         N_REQ    = 3;
    localparam int         SYNC_GAP = 4;
    localparam logic [7:0] HDR      = 8'h55;
`ifdef UART_TX_SCHED_CHECKSUM_EN
    localparam int PKT_LEN = 5;
`else
    localparam int PKT_LEN = 4;
`endif

    logic                clk     = 1'b0;
    logic                rst     = 1'b1;
    logic                link_up = 1'b0;
    logic                tx_full = 1'b0;
    logic [N_REQ-1:0]    req     = '0;
    logic [16*N_REQ-1:0] payload = '0;
    logic [N_REQ-1:0]    gnt;
    logic [7:0]          w_data;
    logic                wr_uart;
    logic                busy;

    uart_tx_sched #(.N_REQ(N_REQ), .SYNC_GAP(SYNC_GAP), .HDR_BYTE(HDR)) dut (
        .clk(clk), .rst(rst), .link_up(link_up), .tx_full(tx_full), .req(req),
        .payload(payload), .gnt(gnt), .w_data(w_data), .wr_uart(wr_uart), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0]       exp_q[$];
    logic [N_REQ-1:0] gnt_q[$];

    int cyc = 0, last_rst_edge = 0, last_wr_cyc = 0, gnt_cyc = 0, pkt_pos = 0, sync_count = 0;
    int ref_c, gap_exp;
    bit sync_mode = 1'b1, sync_first = 1'b0, no_bp = 1'b0, rand_bp = 1'b0;
    int sync_first_gap = SYNC_GAP + 1;
    int m_ptr = 0;
    logic [N_REQ-1:0] last_gnt = '0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) last_rst_edge <= cyc + 1;
    end

    // Monitor: every grant and every written byte is matched against the scoreboard.
    always @(negedge clk) begin
        if (gnt != '0) begin
            gnt_cyc = cyc;
            if (gnt_q.size() == 0) check("gnt_unexpected", int'(gnt), 0);
            else check("gnt", int'(gnt), int'(gnt_q.pop_front()));
            check("busy_at_gnt", int'(busy), 1);
        end
        if (wr_uart) begin
            if (sync_mode) begin
                check("sync_byte", int'(w_data), 'hAA);
                ref_c   = (last_rst_edge > last_wr_cyc) ? last_rst_edge : last_wr_cyc;
                gap_exp = sync_first ? sync_first_gap : SYNC_GAP + 1;
                check("sync_gap", cyc - ref_c, gap_exp);
                sync_first = 1'b0;
                sync_count++;
            end else if (exp_q.size() == 0) begin
                check("unexpected_write", int'(wr_uart), 0);
            end else begin
                check("pkt_byte", int'(w_data), int'(exp_q.pop_front()));
                check("busy_at_byte", int'(busy), (pkt_pos != PKT_LEN - 1) ? 1 : 0);
                if (no_bp) begin
                    if (pkt_pos == 0) check("gnt_to_hdr", cyc - gnt_cyc, 1);
                    else check("back_to_back", cyc - last_wr_cyc, 1);
                end
                pkt_pos = (pkt_pos + 1) % PKT_LEN;
            end
            last_wr_cyc = cyc;
        end
        if (rst) pkt_pos = 0;
    end

    task automatic tick();
        @(negedge clk);
        last_gnt = gnt;
        req = req & ~gnt;
        if (rand_bp) tx_full = ($urandom_range(0, 3) == 0);
    endtask

    // Reference model: grants go to set mask bits in ascending order starting at the rr pointer.
    task automatic issue(input logic [N_REQ-1:0] mask, input bit use_fixed, input logic [15:0] fixed);
        int i;
        int last;
        logic [15:0] p;
        logic [7:0] id;
        logic [N_REQ-1:0] oh;
        last = m_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            i = (m_ptr + k) % N_REQ;
            if (mask[i]) begin
                p = use_fixed ? fixed : 16'($urandom);
                payload[16*i +: 16] = p;
                oh = '0;
                oh[i] = 1'b1;
                gnt_q.push_back(oh);
                id = 8'(i);
                exp_q.push_back(HDR);
                exp_q.push_back(id);
                exp_q.push_back(p[15:8]);
                exp_q.push_back(p[7:0]);
`ifdef UART_TX_SCHED_CHECKSUM_EN
                exp_q.push_back(HDR ^ id ^ p[15:8] ^ p[7:0]);
`endif
                last = i;
            end
        end
        m_ptr = (last + 1) % N_REQ;
        req = req | mask;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || gnt_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            check("drain_timeout", exp_q.size() + gnt_q.size(), 0);
            exp_q.delete();
            gnt_q.delete();
        end
        tick();
        tick();
    endtask

    task automatic wait_gnt(output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 40) begin
            tick();
            ok = (last_gnt != '0);
            n++;
        end
        if (!ok) check("gnt_timeout", 0, 1);
    endtask

    initial begin
        int start;
        bit ok;

        repeat (3) @(negedge clk);
        check("rst_wr_uart", int'(wr_uart), 0);
        check("rst_w_data", int'(w_data), 'hAA);
        check("rst_busy", int'(busy), 0);
        check("rst_gnt", int'(gnt), 0);
        rst = 1'b0;

        start = sync_count;
        repeat (28) tick();
        check("sync_count", sync_count - start, 5);

        link_up = 1'b1;
        repeat (3) tick();
        sync_mode = 1'b0;

        no_bp = 1'b1;
        issue(3'b010, 1'b1, 16'h1234);
        drain(100);
        issue(3'b111, 1'b0, 16'h0);
        drain(100);

        // Backpressure while PH is pending.
        no_bp = 1'b0;
        issue(3'b010, 1'b1, 16'h1234);
        wait_gnt(ok);
        if (ok) begin
            tick();
            tick();
            tx_full = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                check("bp_wr_uart", int'(wr_uart), 0);
                check("bp_w_data", int'(w_data), 0);
            end
            tx_full = 1'b0;
        end
        drain(100);

        // Link drops while ID is pending: packet completes, then sync resumes.
        no_bp = 1'b1;
        issue(3'b001, 1'b0, 16'h0);
        wait_gnt(ok);
        if (ok) begin
            tick();
            link_up = 1'b0;
        end
        drain(100);
        sync_first_gap = SYNC_GAP + 2;
        sync_first = 1'b1;
        sync_mode = 1'b1;
        start = sync_count;
        repeat (14) tick();
        check("sync_after_drop", int'((sync_count - start) >= 2), 1);
        link_up = 1'b1;
        repeat (3) tick();
        sync_mode = 1'b0;

        no_bp = 1'b0;
        rand_bp = 1'b1;
        for (int ph = 0; ph < 10; ph++) begin
            issue(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), 1'b0, 16'h0);
            drain(400);
        end
        rand_bp = 1'b0;
        tx_full = 1'b0;

        // Reset while PL is pending: only HDR, ID, PH reach the FIFO.
        no_bp = 1'b1;
        issue(3'b100, 1'b0, 16'h0);
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        wait_gnt(ok);
        if (ok) begin
            tick();
            tick();
            tick();
            rst = 1'b1;
            tick();
            check("midrst_wr_uart", int'(wr_uart), 0);
            check("midrst_w_data", int'(w_data), 'hAA);
            check("midrst_busy", int'(busy), 0);
            check("midrst_gnt", int'(gnt), 0);
            tick();
            rst = 1'b0;
            m_ptr = 0;
            req = '0;
        end
        drain(50);
        issue(3'b111, 1'b0, 16'h0);
        drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
